// File: rtl/req_encoder_8to3_pkg.sv
// Shared types and constants for the registered 8-to-3 request encoder.
package req_encoder_8to3_pkg;

   localparam int N_REQ = 8;
   localparam int IDX_W = 3;

   typedef enum logic {
      IDLE  = 1'b0,
      OFFER = 1'b1
   } state_t;

endpackage

// File: rtl/req_encoder_8to3_prio_enc.sv
// Combinational priority encoder: picks the highest- or lowest-numbered set bit.
module prio_enc_8to3
   import req_encoder_8to3_pkg::*;
#(
   parameter bit PRIO_HIGH = 1'b1
) (
   input  logic [0:N_REQ-1] vec,
   output logic [IDX_W-1:0] idx,
   output logic             any
);

   always_comb begin
      // NOTE: every output gets a default first so no path through the loop infers a latch.
      idx = '0;
      any = |vec;
      // Later iterations overwrite earlier ones, so the scan order sets the priority.
      if (PRIO_HIGH) begin
         for (int i = 0; i < N_REQ; i++)
            if (vec[i]) idx = IDX_W'(i);
      end else begin
         for (int i = N_REQ - 1; i >= 0; i--)
            if (vec[i]) idx = IDX_W'(i);
      end
   end

endmodule

// File: rtl/req_encoder_8to3.sv
// Registered 8-to-3 priority encoder: latches requests, offers the winner over valid/ready.
module req_encoder_8to3
   import req_encoder_8to3_pkg::*;
#(
   parameter bit PRIO_HIGH = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [0:N_REQ-1] d,
   input  logic             ready,
   output logic [IDX_W-1:0] y,
   output logic             valid,
   output logic [0:N_REQ-1] pend,
   output logic             lost
);

   state_t           state, state_next;
   logic [0:N_REQ-1] cap, clr, pend_next, enc_in;
   logic [IDX_W-1:0] y_next, enc_idx;
   logic             enc_any, lost_next;

   prio_enc_8to3 #(.PRIO_HIGH(PRIO_HIGH)) u_prio (
      .vec (enc_in),
      .idx (enc_idx),
      .any (enc_any)
   );

   assign valid = (state == OFFER);

   always_comb begin
      cap = d & {N_REQ{en}};
      clr = '0;
      if (valid && ready) clr[y] = 1'b1;
      pend_next = (pend & ~clr) | cap;
      lost_next = lost | (|(cap & pend & ~clr));

      // From IDLE only already-latched requests are eligible; on accept the
      // successor is chosen from the updated set for bubble-free service.
      enc_in = (state == OFFER) ? pend_next : pend;

      state_next = state;
      y_next     = y;
      unique case (state)
         IDLE: begin
            if (|pend) begin
               state_next = OFFER;
               y_next     = enc_idx;
            end
         end
         OFFER: begin
            if (ready) begin
               if (enc_any) y_next     = enc_idx;
               else         state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         state <= IDLE;
         y     <= '0;
         pend  <= '0;
         lost  <= 1'b0;
      end else begin
         state <= state_next;
         y     <= y_next;
         pend  <= pend_next;
         lost  <= lost_next;
      end
   end

endmodule
